// File: rtl/div_sequencer.sv
// div_sequencer: restoring shift-and-subtract unsigned divider, one quotient bit per clock
module div_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] q, d, r, q_nx, r_nx;
  logic [WIDTH:0] shifted, trial;
  logic [CW-1:0] cnt;
  logic last, accept, zero;
  assign last = cnt == CW'(WIDTH - 1);
  assign accept = state == IDLE && start;
  assign zero = divisor == '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  // trial subtraction; a negative result (borrow) means restore the shifted remainder
  always_comb begin
    shifted = {r, q[WIDTH-1]};
    trial = shifted - {1'b0, d};
    q_nx = {q[WIDTH-2:0], ~trial[WIDTH]};
    r_nx = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  // next-state: zero divisor skips RUN entirely, DONE always lasts one cycle
  always_comb begin
    state_nx = state;
    if (accept) state_nx = zero ? DONE : RUN;
    else if (state == RUN && last) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  // work registers and result latches; results are captured on the edge entering DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
      d <= '0;
      r <= '0;
      cnt <= '0;
      quotient <= '0;
      remainder <= '0;
      div_zero <= 1'b0;
    end else if (accept && !zero) begin
      q <= dividend;
      d <= divisor;
      r <= '0;
      cnt <= '0;
    end else if (accept) begin
      quotient <= '1;
      remainder <= dividend;
      div_zero <= 1'b1;
    end else if (state == RUN) begin
      q <= q_nx;
      r <= r_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        quotient <= q_nx;
        remainder <= r_nx;
        div_zero <= 1'b0;
      end
    end
  end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Multi-cycle unsigned integer divider controller for the 8-bit computer's arithmetic unit. It sequences a restoring shift-and-subtract algorithm, one quotient bit per clock, around a trial subtractor whose borrow/sign output selects restore or keep. A start/busy/done handshake lets the CPU control logic issue a divide and wait for the quotient and remainder.

Parameters:
WIDTH, 8, operand/result width in bits; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge active
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request a divide; sampled only in IDLE
dividend  input  WIDTH  numerator, captured on accepted start
divisor  input  WIDTH  denominator, captured on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse, results valid
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
div_zero  output  1  registered flag, divisor was zero for the last completed divide

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_zero=0; internal counters and work registers cleared. A reset asserted mid-operation aborts the divide immediately, and no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE with start=1 and divisor!=0: capture Q<=dividend, D<=divisor, R<=0, count<=0, then go to RUN.
- IDLE with start=1 and divisor==0: go directly to DONE with zero-divide results latched (see below). No RUN cycles.
- IDLE with start=0: hold. Outputs keep the last results.
- RUN, one iteration per cycle, MSB first:
  - shifted = {R[WIDTH-1:0], Q[WIDTH-1]} (WIDTH+1 bits).
  - trial = shifted - {1'b0, D}, computed at WIDTH+1 bits; sign = trial[WIDTH] (1 means negative).
  - If sign=0: R<=trial[WIDTH-1:0] and Q<={Q[WIDTH-2:0],1}.
  - Otherwise: R<=shifted[WIDTH-1:0] and Q<={Q[WIDTH-2:0],0}.
  - count increments each cycle. After WIDTH RUN cycles (count==WIDTH-1 on the last one), go to DONE.
- DONE entry latches the outputs:
  - Normal divide: quotient<=Q, remainder<=R, div_zero<=0.
  - Zero divide: quotient<=all ones, remainder<=dividend, div_zero<=1.
- DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally.
- Latency, with the accepted start edge as cycle 0:
  - Normal divide: RUN occupies cycles 1..WIDTH, done is high in cycle WIDTH+1 (cycle 9 for WIDTH=8), and the next start is accepted in cycle WIDTH+2.
  - Zero divide: done is high in cycle 1.
- start while busy (RUN or DONE) is ignored. It is not queued, and operand changes during busy have no effect.
- quotient, remainder and div_zero change only on DONE entry or reset. They are stable while busy and after done.
- Invariant for every non-zero divide: quotient*divisor + remainder == dividend, and remainder < divisor.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, release, start=0 -> busy=0, done=0, quotient=0x00, remainder=0x00, div_zero=0.
- Basic divide: dividend=100, divisor=7, start 1 cycle -> busy high cycles 1..9, done high only in cycle 9, quotient=14, remainder=2, div_zero=0.
- Divisor larger than dividend and boundary values:
  - 0x6F/0xAD -> quotient=0x00, remainder=0x6F.
  - 0xFF/0x01 -> quotient=0xFF, remainder=0x00.
  - 0xFF/0xFF -> quotient=0x01, remainder=0x00.
  - 0x00/0x05 -> quotient=0x00, remainder=0x00.
- Divide by zero: dividend=0x42, divisor=0x00 -> done high in cycle 1, quotient=0xFF, remainder=0x42, div_zero=1. A following 0x10/0x04 divide clears div_zero and gives quotient=0x04, remainder=0x00.
- Protocol: start held high across a whole divide, with dividend/divisor changed to 0x09/0x03 in cycle 4 -> the first result is unaffected. Exactly one new divide is accepted in cycle 10, after done, using 0x09/0x03 -> quotient=3, remainder=0.
- Reset mid-op: start 200/9, assert reset in cycle 5 -> busy=0 and outputs=0 immediately (asynchronous), and no done pulse appears. After release, 200/9 -> quotient=22, remainder=2.
- Randomised sweep: 500 random operand pairs with divisor != 0 -> check the invariant and the 9-cycle latency on every divide.
